mac_lane_pipe: RTL

//  Parametrised, pipelined, multi-lane sign-magnitude fixed-point multiply-accumulate unit.

---
 rtl/mac_lane_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mac_lane_pipe.sv
// mac_lane_pipe -- pipelined multi-lane sign-magnitude fixed-point MAC.
//
// LANES independent accumulators share one valid/clear control path. Each
// lane multiplies |A|*|B| in stage 1, scales the product down by FRAC_W, and
// in stage 2 adds the signed product to its accumulator (or to zero when
// acc_clr travels with the sample), saturating to +/-(2^MAG_W-1).
//
// Optional build macro: MAC_ROUND_EN -- stage-1 product magnitude rounds
// half-up instead of truncating toward zero. Latency is the same either way.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (clears pipeline, out, ovf)
//   in_valid   A/B carry a sample for every lane this cycle
//   acc_clr    clear accumulators, ordered with the sample stream
//   A, B       LANES packed sign-magnitude words, lane i at [i*W +: W]
//   out        LANES packed sign-magnitude accumulators
//   out_valid  one-cycle pulse when out was updated by an accepted sample
//   ovf        sticky per-lane saturation flags

// Per-lane datapath: stage-1 product register and stage-2 accumulator.
module mac_lane #(
   parameter int INT_W  = 21,
   parameter int FRAC_W = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [INT_W+FRAC_W:0]   i_a,
   input  logic [INT_W+FRAC_W:0]   i_b,
   input  logic                    i_s1_vld,
   input  logic                    i_s1_clr,
   output logic [INT_W+FRAC_W:0]   o_out,
   output logic                    o_ovf
);
   localparam int MAG_W = INT_W + FRAC_W;
   localparam int W     = MAG_W + 1;
   localparam int PM_W  = 2 * MAG_W;     // full product width, keeps saturation exact
   localparam int SUM_W = PM_W + 2;      // room for sign plus one carry

   localparam logic signed [SUM_W-1:0] MAX_S = {{(SUM_W-MAG_W){1'b0}}, {MAG_W{1'b1}}};

   logic [PM_W-1:0] w_prod_full;
   logic [PM_W-1:0] w_prod_adj;
   logic [PM_W-1:0] r_mag;
   logic            r_sgn;
   logic [W-1:0]    r_out;
   logic            r_ovf;

   assign w_prod_full = {{MAG_W{1'b0}}, i_a[MAG_W-1:0]} * {{MAG_W{1'b0}}, i_b[MAG_W-1:0]};

`ifdef MAC_ROUND_EN
   // Rounding on the magnitude keeps the result symmetric about zero.
   localparam logic [PM_W-1:0] RND = {{(PM_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
   assign w_prod_adj = (w_prod_full + RND) >> FRAC_W;
`else
   assign w_prod_adj = w_prod_full >> FRAC_W;
`endif

   // Stage 2 arithmetic in two's complement.
   logic signed [SUM_W-1:0] w_acc_s, w_prod_s, w_base, w_add, w_sum;
   logic                    w_pos_sat, w_neg_sat;
   logic [MAG_W-1:0]        w_sum_mag;
   logic [W-1:0]            w_next;

   always_comb begin
      w_acc_s  = {{(SUM_W-MAG_W){1'b0}}, r_out[MAG_W-1:0]};
      if (r_out[W-1]) w_acc_s = -w_acc_s;
      w_prod_s = {2'b00, r_mag};
      if (r_sgn) w_prod_s = -w_prod_s;
      w_base    = i_s1_clr ? '0 : w_acc_s;
      w_add     = i_s1_vld ? w_prod_s : '0;
      w_sum     = w_base + w_add;
      w_pos_sat = (w_sum > MAX_S);
      w_neg_sat = (w_sum < -MAX_S);
      // Only used when not saturated, so the low MAG_W bits hold |sum|.
      w_sum_mag = w_sum[SUM_W-1] ? (~w_sum[MAG_W-1:0] + 1'b1) : w_sum[MAG_W-1:0];
      if (w_pos_sat)      w_next = {1'b0, {MAG_W{1'b1}}};
      else if (w_neg_sat) w_next = {1'b1, {MAG_W{1'b1}}};
      else                w_next = {w_sum[SUM_W-1], w_sum_mag};  // zero sum -> sign 0
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mag <= '0;
         r_sgn <= 1'b0;
         r_out <= '0;
         r_ovf <= 1'b0;
      end else begin
         r_mag <= w_prod_adj;
         r_sgn <= i_a[W-1] ^ i_b[W-1];
         if (i_s1_vld || i_s1_clr) begin
            r_out <= w_next;
            // Clear takes effect before this sample's saturation is folded in.
            r_ovf <= (r_ovf & ~i_s1_clr) | w_pos_sat | w_neg_sat;
         end
      end
   end

   assign o_out = r_out;
   assign o_ovf = r_ovf;
endmodule

module mac_lane_pipe #(
   parameter int INT_W  = 21,
   parameter int FRAC_W = 10,
   parameter int LANES  = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   input  logic                                acc_clr,
   input  logic [LANES*(1+INT_W+FRAC_W)-1:0]   A,
   input  logic [LANES*(1+INT_W+FRAC_W)-1:0]   B,
   output logic [LANES*(1+INT_W+FRAC_W)-1:0]   out,
   output logic                                out_valid,
   output logic [LANES-1:0]                    ovf
);
   localparam int W = 1 + INT_W + FRAC_W;

   // r_vld_pipe[1]: stage-1 valid, r_vld_pipe[2]: out_valid.
   logic [2:1] r_vld_pipe;
   logic       r_s1_clr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_s1_clr   <= 1'b0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[1], in_valid};
         r_s1_clr   <= acc_clr;
      end
   end

   assign out_valid = r_vld_pipe[2];

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      mac_lane #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_a      (A[gi*W +: W]),
         .i_b      (B[gi*W +: W]),
         .i_s1_vld (r_vld_pipe[1]),
         .i_s1_clr (r_s1_clr),
         .o_out    (out[gi*W +: W]),
         .o_ovf    (ovf[gi])
      );
   end
endmodule
